// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: request/grant arbiter for the single VGA adapter plot port.
// A grant is held for a whole burst, and the granted pixel stream is registered
// towards the adapter, so pixels from different engines are never interleaved.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no grant held; the lowest-index request wins and is granted next cycle
// S_BURST | one requester owns the port until its last pixel or until it drops req
module vga_plot_arbiter #(
    parameter int N     = 5,
    parameter int CNT_W = 17
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       plot_in,
    input  logic [N-1:0]       last_in,
    input  logic [9*N-1:0]     x_in,
    input  logic [8*N-1:0]     y_in,
    input  logic [3*N-1:0]     colour_in,
    output logic [N-1:0]       gnt,
    output logic [8:0]         vga_x,
    output logic [7:0]         vga_y,
    output logic [2:0]         vga_colour,
    output logic               vga_plot,
    output logic               busy,
    output logic               abort,
    output logic [CNT_W-1:0]   pixel_count
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t             r_state, w_state_nxt;
    logic [N-1:0]       r_gnt, w_gnt_nxt;
    logic [8:0]         r_x, w_x_nxt;
    logic [7:0]         r_y, w_y_nxt;
    logic [2:0]         r_colour, w_colour_nxt;
    logic               r_plot, w_plot_nxt;
    logic               r_abort, w_abort_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic [N-1:0]       w_pick;
    logic [8:0]         w_sel_x;
    logic [7:0]         w_sel_y;
    logic [2:0]         w_sel_colour;
    logic               w_req_g;
    logic               w_accept;
    logic               w_last;

    // Lowest set request bit: x & -x isolates it, giving index 0 top priority.
    assign w_pick   = req & (~req + N'(1));
    // Only strobes of the current grant holder count; everyone else is masked off.
    assign w_req_g  = |(req & r_gnt);
    assign w_accept = |(plot_in & r_gnt);
    assign w_last   = |(plot_in & last_in & r_gnt);

    // Select the pixel fields of the requester that holds the grant.
    always_comb begin
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_colour = '0;
        for (int i = 0; i < N; i++) begin
            if (r_gnt[i]) begin
                w_sel_x      = x_in[9*i +: 9];
                w_sel_y      = y_in[8*i +: 8];
                w_sel_colour = colour_in[3*i +: 3];
            end
        end
    end

    // Next-state and next-output logic for the grant FSM and pixel pipeline.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_colour_nxt = r_colour;
        w_plot_nxt   = 1'b0;
        w_abort_nxt  = 1'b0;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                if (|req) begin
                    w_gnt_nxt   = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                // A pixel in the releasing cycle (last or req drop) is still forwarded.
                if (w_accept) begin
                    w_plot_nxt   = 1'b1;
                    w_x_nxt      = w_sel_x;
                    w_y_nxt      = w_sel_y;
                    w_colour_nxt = w_sel_colour;
                    if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                // A last pixel wins over a simultaneous req drop: normal release.
                if (w_last) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (!w_req_g) begin
                    w_gnt_nxt   = '0;
                    w_abort_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any burst without an abort pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_abort  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_colour <= w_colour_nxt;
            r_plot   <= w_plot_nxt;
            r_abort  <= w_abort_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign busy        = |r_gnt;
    assign vga_x       = r_x;
    assign vga_y       = r_y;
    assign vga_colour  = r_colour;
    assign vga_plot    = r_plot;
    assign abort       = r_abort;
    assign pixel_count = r_cnt;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Testbench for vga_plot_arbiter: scenario tasks plus a pixel scoreboard.
module tb_vga_plot_arbiter;

    localparam int N     = 5;
    localparam int CNT_W = 17;

    logic               clock = 1'b0;
    logic               reset;
    logic [N-1:0]       req, plot_in, last_in;
    logic [9*N-1:0]     x_in;
    logic [8*N-1:0]     y_in;
    logic [3*N-1:0]     colour_in;
    logic [N-1:0]       gnt;
    logic [8:0]         vga_x;
    logic [7:0]         vga_y;
    logic [2:0]         vga_colour;
    logic               vga_plot, busy, abort;
    logic [CNT_W-1:0]   pixel_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [19:0] exp_q[$];

    vga_plot_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .req(req), .plot_in(plot_in), .last_in(last_in),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .gnt(gnt),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .abort(abort), .pixel_count(pixel_count)
    );

    always #10 clock = ~clock;

    // Scoreboard: every plotted pixel must match the oldest expected pixel.
    always @(posedge clock) begin
        #1;
        if (vga_plot === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra_plot: got plot x=%0d y=%0d c=%0d, expected no pixel", vga_x, vga_y, vga_colour);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({vga_x, vga_y, vga_colour} !== e) begin
                    n_fail++;
                    $display("FAIL sb_pixel: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                             vga_x, vga_y, vga_colour, e[19:11], e[10:3], e[2:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_pix(input int i, input logic [8:0] x, input logic [7:0] y,
                             input logic [2:0] c, input logic last, input logic fwd);
        plot_in[i]          = 1'b1;
        last_in[i]          = last;
        x_in[9*i +: 9]      = x;
        y_in[8*i +: 8]      = y;
        colour_in[3*i +: 3] = c;
        if (fwd) exp_q.push_back({x, y, c});
    endtask

    task automatic clear_pix();
        plot_in = '0;
        last_in = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; clear_pix();
        x_in = '0; y_in = '0; colour_in = '0;
        tick(); tick();
        n_checks++;
        if ({gnt, vga_plot, vga_x, vga_y, vga_colour, busy, abort, pixel_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b plot=%b x=%0d y=%0d c=%0d busy=%b abort=%b cnt=%0d, expected all 0",
                     gnt, vga_plot, vga_x, vga_y, vga_colour, busy, abort, pixel_count);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (gnt !== '0) begin n_fail++; $display("FAIL reset_idle_gnt: got %b expected 00000", gnt); end
    endtask

    task automatic test_single_burst();
        req[1] = 1'b1;
        tick();
        n_checks++;
        if (gnt !== 5'b00010 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_grant: got gnt=%b busy=%b expected 00010 1", gnt, busy);
        end
        for (int j = 0; j < 4; j++) begin
            drive_pix(1, 9'(10 + j), 8'd20, 3'b100, j == 3, 1'b1);
            tick();
            n_checks++;
            if (vga_plot !== 1'b1 || vga_x !== 9'(10 + j)) begin
                n_fail++; $display("FAIL single_pixel%0d: got plot=%b x=%0d expected 1 %0d", j, vga_plot, vga_x, 10 + j);
            end
        end
        n_checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_release: got gnt=%b busy=%b expected 00000 0", gnt, busy);
        end
        req = '0; clear_pix();
        tick();
        n_checks++;
        if (vga_plot !== 1'b0 || pixel_count !== 17'd4 || vga_x !== 9'd13 || abort !== 1'b0) begin
            n_fail++; $display("FAIL single_after: got plot=%b cnt=%0d x=%0d abort=%b expected 0 4 13 0",
                               vga_plot, pixel_count, vga_x, abort);
        end
    endtask

    task automatic test_priority();
        req[3] = 1'b1;
        tick();
        n_checks++;
        if (gnt !== 5'b01000) begin n_fail++; $display("FAIL prio_grant3: got %b expected 01000", gnt); end
        drive_pix(3, 9'd50, 8'd1, 3'd2, 1'b0, 1'b1);
        tick();
        req[0] = 1'b1;
        drive_pix(3, 9'd51, 8'd1, 3'd2, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (gnt !== 5'b01000) begin n_fail++; $display("FAIL prio_no_preempt: got %b expected 01000", gnt); end
        drive_pix(3, 9'd52, 8'd1, 3'd2, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (gnt !== 5'b00000) begin n_fail++; $display("FAIL prio_gap: got %b expected 00000", gnt); end
        req[3] = 1'b0; clear_pix();
        tick();
        n_checks++;
        if (gnt !== 5'b00001) begin n_fail++; $display("FAIL prio_grant0: got %b expected 00001", gnt); end
        drive_pix(0, 9'd7, 8'd7, 3'd7, 1'b1, 1'b1);
        tick();
        req = '0; clear_pix();
        tick();
    endtask

    task automatic test_simultaneous();
        int order[3] = '{1, 2, 4};
        req = 5'b10110;
        for (int k = 0; k < 3; k++) begin
            logic [N-1:0] want;
            want = '0;
            want[order[k]] = 1'b1;
            tick();
            n_checks++;
            if (gnt !== want) begin n_fail++; $display("FAIL simul_grant%0d: got %b expected %b", k, gnt, want); end
            drive_pix(order[k], 9'(200 + k), 8'd3, 3'(k), 1'b1, 1'b1);
            tick();
            req[order[k]] = 1'b0; clear_pix();
            n_checks++;
            if (gnt !== '0) begin n_fail++; $display("FAIL simul_gap%0d: got %b expected 00000", k, gnt); end
        end
        tick();
    endtask

    task automatic test_isolation();
        req[2] = 1'b1;
        tick();
        n_checks++;
        if (gnt !== 5'b00100) begin n_fail++; $display("FAIL iso_grant: got %b expected 00100", gnt); end
        for (int j = 0; j < 4; j++) begin
            drive_pix(2, 9'(100 + j), 8'd9, 3'd5, j == 3, 1'b1);
            if (j == 1) drive_pix(0, 9'd300, 8'd5, 3'd7, 1'b1, 1'b0);
            tick();
            plot_in[0] = 1'b0; last_in[0] = 1'b0;
            n_checks++;
            if (vga_x === 9'd300 || vga_plot !== 1'b1) begin
                n_fail++; $display("FAIL iso_pixel%0d: got x=%0d plot=%b expected x!=300 plot=1", j, vga_x, vga_plot);
            end
        end
        req = '0; clear_pix();
        for (int j = 0; j < 2; j++) begin
            tick();
            n_checks++;
            if (vga_x === 9'd300 || vga_plot !== 1'b0) begin
                n_fail++; $display("FAIL iso_after%0d: got x=%0d plot=%b expected x!=300 plot=0", j, vga_x, vga_plot);
            end
        end
    endtask

    task automatic test_abort();
        req[4] = 1'b1;
        tick();
        n_checks++;
        if (gnt !== 5'b10000) begin n_fail++; $display("FAIL abort_grant: got %b expected 10000", gnt); end
        for (int j = 0; j < 3; j++) begin
            drive_pix(4, 9'(40 + j), 8'd40, 3'd1, 1'b0, 1'b1);
            tick();
            n_checks++;
            if (abort !== 1'b0) begin n_fail++; $display("FAIL abort_early%0d: got %b expected 0", j, abort); end
        end
        req = '0; clear_pix();
        tick();
        n_checks++;
        if (abort !== 1'b1 || gnt !== '0 || pixel_count !== 17'd3) begin
            n_fail++; $display("FAIL abort_pulse: got abort=%b gnt=%b cnt=%0d expected 1 00000 3", abort, gnt, pixel_count);
        end
        tick();
        n_checks++;
        if (abort !== 1'b0) begin n_fail++; $display("FAIL abort_one_cycle: got %b expected 0", abort); end
    endtask

    task automatic test_reset_mid_burst();
        req[0] = 1'b1;
        tick();
        n_checks++;
        if (gnt !== 5'b00001) begin n_fail++; $display("FAIL rmid_grant: got %b expected 00001", gnt); end
        for (int j = 0; j < 1200; j++) begin
            drive_pix(0, 9'(j % 320), 8'(j / 320), 3'(j % 8), 1'b0, 1'b1);
            tick();
        end
        n_checks++;
        if (pixel_count !== 17'd1200) begin n_fail++; $display("FAIL rmid_count: got %0d expected 1200", pixel_count); end
        clear_pix();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({gnt, vga_plot, vga_x, vga_y, vga_colour, busy, abort, pixel_count} !== '0) begin
            n_fail++;
            $display("FAIL rmid_reset: got gnt=%b plot=%b x=%0d y=%0d c=%0d busy=%b abort=%b cnt=%0d, expected all 0",
                     gnt, vga_plot, vga_x, vga_y, vga_colour, busy, abort, pixel_count);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (gnt !== 5'b00001 || abort !== 1'b0) begin
            n_fail++; $display("FAIL rmid_regrant: got gnt=%b abort=%b expected 00001 0", gnt, abort);
        end
        drive_pix(0, 9'd319, 8'd239, 3'd6, 1'b1, 1'b1);
        tick();
        req = '0; clear_pix();
        tick();
    endtask

    task automatic test_drain();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d pending pixels expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_priority();
        test_simultaneous();
        test_isolation();
        test_abort();
        test_reset_mid_burst();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
